player_sprite_blitter: RTL and testbench
========================================

// Module: player_sprite_blitter
// PURPOSE
//  Downstream consumer of the player position logic. Once per frame it renders the
//  player box into the back half of the dual frame buffer, erasing the box drawn
//  there two frames earlier. It then requests a buffer swap.
//  Sits between the player position outputs and the SRAM write arbiter.
// PARAMETERS
//  SCREEN_W      640    visible width in pixels; also the row pitch
//  SCREEN_H      480    visible height in pixels
//  SPRITE_SIZE   4      half-extent; the box is (2*S+1)x(2*S+1), centred on (PlayerX,PlayerY)
//  SPRITE_COLOR  8'hE0  palette index written when drawing
//  BG_COLOR      8'h00  palette index written when erasing
// PORTS
//  Clk           in   1   system clock
//  Reset         in   1   synchronous, active-high
//  frame_start   in   1   1-cycle pulse at vsync, already synchronised to Clk
//  PlayerX       in   10  player centre X, unsigned
//  PlayerY       in   10  player centre Y, unsigned
//  wr_req        out  1   write request to the arbiter
//  wr_addr       out  20  buf*SCREEN_W*SCREEN_H + y*SCREEN_W + x
//  wr_data       out  8   palette index
//  wr_ack        in   1   arbiter accepts the write this cycle
//  front_buf     out  1   buffer being displayed; drawing always targets ~front_buf
//  buf_swap      out  1   1-cycle pulse on the same edge front_buf toggles
//  busy          out  1   high from the IDLE exit until the SWAP state completes
//  frame_overrun out  1   sticky; set by a frame_start that arrives while busy
// BEHAVIOUR
//  Reset (Clk-synchronous, Reset=1 sampled on posedge Clk):
//   - Outputs: wr_req=0, wr_addr=0, wr_data=0, front_buf=0, buf_swap=0, busy=0, frame_overrun=0.
//   - Both per-buffer old-position valid bits are cleared. State returns to IDLE.
//   - A reset mid-blit abandons the blit; wr_req is low on the cycle after reset is sampled.
//  FSM: IDLE -> LATCH -> ERASE -> DRAW -> SWAP -> IDLE.
//   IDLE:  on frame_start, go to LATCH.
//   LATCH: capture PlayerX/PlayerY into cx/cy; inputs are ignored until the next IDLE.
//          Go to ERASE if the back buffer's old-valid bit is set, else go to DRAW.
//   ERASE: scan the box at the back buffer's stored old position; write BG_COLOR.
//   DRAW:  scan the box at (cx,cy); write SPRITE_COLOR.
//   SWAP:  store (cx,cy) as the back buffer's old position and set its valid bit.
//          Toggle front_buf, pulse buf_swap, return to IDLE.
//  Scan order: row-major; y from c-S to c+S outer, x from c-S to c+S inner.
//  Coordinate arithmetic: 11-bit signed.
//   - A pixel is in range only if 0<=x<SCREEN_W and 0<=y<SCREEN_H.
//   - An out-of-range pixel is skipped in exactly 1 cycle with wr_req=0.
//  Handshake:
//   - wr_req, wr_addr and wr_data stay stable until a cycle with wr_req&&wr_ack.
//   - The next pixel is presented on the following cycle; there are no idle gaps.
//   - When wr_ack is held high, each in-range pixel takes exactly 1 cycle.
//  Latency with wr_ack tied high, no erase, no clipping:
//   frame_start at cycle 0 -> LATCH at 1 -> first wr_req at 2 -> last write at 2+(2S+1)^2-1 -> buf_swap on the next cycle.
//  frame_start outside IDLE: ignored and frame_overrun set. frame_start in the SWAP cycle counts as busy.
//  frame_overrun clears only on Reset.
// CONFIGURATION
//  PLAYER_BLIT_ERASE_EN defined:
//   - Behaviour as above.
//  PLAYER_BLIT_ERASE_EN undefined:
//   - No ERASE state and no stored old positions; LATCH always goes to DRAW.
//   - Trails stay in the buffer. This saves registers for static-background tests.
// TESTING
//  1 Reset; X=320, Y=240, S=4, wr_ack=1, one frame_start -> 81 writes of 8'hE0.
//    First wr_addr=458556 (buf1, y=236, x=316), last=463684. Then buf_swap, front_buf=1, busy=0.
//  2 Second frame at X=330, Y=240 -> draws buf0 with no erase (buf0 not valid).
//    Third frame at X=340 -> erases buf1 at (320,240) with 81 writes of 8'h00,
//    then draws buf1 at (340,240).
//  3 X=2, Y=2 -> only 49 writes (x,y in 0..6); skipped pixels show 1-cycle wr_req=0 gaps.
//    First addr=307200.
//  4 wr_ack held low 3 cycles per write -> wr_req/addr/data held stable each time;
//    81 writes complete in order.
//  5 frame_start pulsed mid-DRAW -> frame_overrun=1 and sticky; the current blit completes unchanged.
//  6 Reset asserted mid-ERASE -> next cycle wr_req=0, front_buf=0, busy=0.
//    A later frame_start performs a fresh no-erase draw into buf1.

Source files
------------

// File: rtl/player_sprite_blitter.sv
// Player sprite blitter: once per frame, draws the player box into the back
// half of a dual frame buffer and then requests a buffer swap.
// Optional feature macro: PLAYER_BLIT_ERASE_EN. When it is defined, the box
// drawn into a buffer two frames earlier is erased before the new box is drawn.
// When it is undefined, old boxes are left in place as trails.
module player_sprite_blitter #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned SPRITE_SIZE  = 4,
    parameter logic [7:0]  SPRITE_COLOR = 8'hE0,
    parameter logic [7:0]  BG_COLOR     = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  PlayerX,
    input  logic [9:0]  PlayerY,
    output logic        wr_req,
    output logic [19:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic        front_buf,
    output logic        buf_swap,
    output logic        busy,
    output logic        frame_overrun
);

    localparam int unsigned       SPAN     = 2 * SPRITE_SIZE + 1;
    localparam int unsigned       CW       = $clog2(SPAN);
    localparam logic [CW-1:0]     LAST     = CW'(SPAN - 1);
    localparam logic signed [10:0] HALF    = 11'(SPRITE_SIZE);
    localparam logic signed [10:0] W_LIM   = 11'(SCREEN_W);
    localparam logic signed [10:0] H_LIM   = 11'(SCREEN_H);
    localparam logic [19:0]       BUF_SIZE = 20'(SCREEN_W * SCREEN_H);
    localparam logic [19:0]       PITCH    = 20'(SCREEN_W);

`ifdef PLAYER_BLIT_ERASE_EN
    typedef enum logic [2:0] {StIdle, StLatch, StErase, StDraw, StSwap} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLatch, StDraw, StSwap} state_e;
`endif

    state_e              state_q, state_d;
    logic                front_q;
    logic                overrun_q;
    // Centre of the box currently being scanned, and the scan offsets within it
    logic signed [10:0]  sx_q, sy_q;
    logic [CW-1:0]       dx_q, dy_q;

    logic                back;
    logic                erasing;
    logic                scanning;
    logic                in_range;
    logic                advance;
    logic                scan_last;
    logic signed [10:0]  px, py;

`ifdef PLAYER_BLIT_ERASE_EN
    // Latched player centre plus the last box drawn into each buffer
    logic signed [10:0]  cx_q, cy_q;
    logic signed [10:0]  old_x_q [2];
    logic signed [10:0]  old_y_q [2];
    logic [1:0]          old_valid_q;

    assign erasing = (state_q == StErase);
`else
    assign erasing = 1'b0;
`endif

    assign back          = ~front_q;
    assign scanning      = (state_q == StDraw) || erasing;
    assign front_buf     = front_q;
    // Combinational so the pulse is seen on the same edge that toggles front_buf
    assign buf_swap      = (state_q == StSwap);
    assign busy          = (state_q != StIdle);
    assign frame_overrun = overrun_q;

    // Current pixel, clipping and write-port outputs
    always_comb begin
        px        = sx_q - HALF + $signed({{(11 - CW){1'b0}}, dx_q});
        py        = sy_q - HALF + $signed({{(11 - CW){1'b0}}, dy_q});
        in_range  = !px[10] && !py[10] && (px < W_LIM) && (py < H_LIM);
        wr_req    = scanning && in_range;
        wr_addr   = '0;
        wr_data   = '0;
        if (wr_req) begin
            wr_addr = (front_q ? 20'd0 : BUF_SIZE) + 20'(py[9:0]) * PITCH + 20'(px[9:0]);
            wr_data = erasing ? BG_COLOR : SPRITE_COLOR;
        end
        // Clipped pixels retire in one cycle without waiting for the arbiter
        advance   = !in_range || wr_ack;
        scan_last = scanning && advance && (dx_q == LAST) && (dy_q == LAST);
    end

    // Next-state logic for the per-frame sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (frame_start) state_d = StLatch;
`ifdef PLAYER_BLIT_ERASE_EN
            StLatch: state_d = old_valid_q[back] ? StErase : StDraw;
            StErase: if (scan_last) state_d = StDraw;
`else
            StLatch: state_d = StDraw;
`endif
            StDraw:  if (scan_last) state_d = StSwap;
            StSwap:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, scan counters, buffer select and overrun flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            front_q   <= 1'b0;
            overrun_q <= 1'b0;
            sx_q      <= '0;
            sy_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
`ifdef PLAYER_BLIT_ERASE_EN
            cx_q        <= '0;
            cy_q        <= '0;
            old_valid_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (frame_start && (state_q != StIdle)) overrun_q <= 1'b1;

            if (state_q == StLatch) begin
                dx_q <= '0;
                dy_q <= '0;
                sx_q <= $signed({1'b0, PlayerX});
                sy_q <= $signed({1'b0, PlayerY});
`ifdef PLAYER_BLIT_ERASE_EN
                cx_q <= $signed({1'b0, PlayerX});
                cy_q <= $signed({1'b0, PlayerY});
                if (old_valid_q[back]) begin
                    sx_q <= old_x_q[back];
                    sy_q <= old_y_q[back];
                end
`endif
            end

            if (scanning && advance) begin
                if (dx_q == LAST) begin
                    dx_q <= '0;
                    if (dy_q == LAST) begin
                        dy_q <= '0;
`ifdef PLAYER_BLIT_ERASE_EN
                        // Erase done: retarget the scan at the new centre
                        if (erasing) begin
                            sx_q <= cx_q;
                            sy_q <= cy_q;
                        end
`endif
                    end else begin
                        dy_q <= dy_q + 1'b1;
                    end
                end else begin
                    dx_q <= dx_q + 1'b1;
                end
            end

            if (state_q == StSwap) begin
                front_q <= ~front_q;
`ifdef PLAYER_BLIT_ERASE_EN
                old_x_q[back]     <= cx_q;
                old_y_q[back]     <= cy_q;
                old_valid_q[back] <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_player_sprite_blitter.sv
// Directed testbench for player_sprite_blitter (default SPRITE_SIZE=4, 640x480).
// Expectations follow the PLAYER_BLIT_ERASE_EN macro when it is defined.
module tb_player_sprite_blitter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  PlayerX = '0;
    logic [9:0]  PlayerY = '0;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack = 1'b0;
    logic        front_buf;
    logic        buf_swap;
    logic        busy;
    logic        frame_overrun;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [19:0] cap_addr[$];
    logic [7:0]  cap_data[$];
    int          cap_gaps;
    int          cap_unstable;
    int          cap_swap_cycle;

    player_sprite_blitter dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .PlayerX       (PlayerX),
        .PlayerY       (PlayerY),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .front_buf     (front_buf),
        .buf_swap      (buf_swap),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Address of scan index i of an unclipped 9x9 box centred on (cx,cy)
    function automatic int exp_addr(input int b, input int cx, input int cy, input int i);
        return b * 307200 + (cy - 4 + i / 9) * 640 + (cx - 4 + i % 9);
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        frame_start = 1'b0;
        wr_ack = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // One frame: pulse frame_start, acknowledge writes after ack_delay low cycles,
    // collect accepted writes until buf_swap. inject>0 re-pulses frame_start then.
    task automatic run_frame(input int x, input int y, input int ack_delay, input int inject);
        int          wait_cnt;
        logic [19:0] hold_addr;
        logic [7:0]  hold_data;
        cap_addr.delete();
        cap_data.delete();
        cap_gaps = 0;
        cap_unstable = 0;
        cap_swap_cycle = -1;
        wait_cnt = 0;
        hold_addr = '0;
        hold_data = '0;
        @(negedge Clk);
        PlayerX = 10'(x);
        PlayerY = 10'(y);
        frame_start = 1'b1;
        wr_ack = (ack_delay == 0);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge Clk);
            frame_start = (cyc == inject);
            // Position must be ignored once latched
            if (cyc == 3) begin
                PlayerX = 10'(x + 77);
                PlayerY = 10'(y + 33);
            end
            if (buf_swap) begin
                cap_swap_cycle = cyc;
                break;
            end
            if (wr_req) begin
                if (wait_cnt > 0 && (wr_addr !== hold_addr || wr_data !== hold_data))
                    cap_unstable++;
                hold_addr = wr_addr;
                hold_data = wr_data;
                if (wait_cnt < ack_delay) begin
                    wr_ack = 1'b0;
                    wait_cnt++;
                end else begin
                    wr_ack = 1'b1;
                    cap_addr.push_back(wr_addr);
                    cap_data.push_back(wr_data);
                    wait_cnt = 0;
                end
            end else begin
                cap_gaps++;
                wr_ack = (ack_delay == 0);
            end
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] act [7];
        string       nm [7];
        do_reset();
        act[0] = 32'(wr_req);    nm[0] = "wr_req";
        act[1] = 32'(wr_addr);   nm[1] = "wr_addr";
        act[2] = 32'(wr_data);   nm[2] = "wr_data";
        act[3] = 32'(front_buf); nm[3] = "front_buf";
        act[4] = 32'(buf_swap);  nm[4] = "buf_swap";
        act[5] = 32'(busy);      nm[5] = "busy";
        act[6] = 32'(frame_overrun); nm[6] = "frame_overrun";
        for (int i = 0; i < 7; i++) begin
            total_cnt++;
            if (act[i] !== 32'd0)
                $display("FAIL reset_%s: got %0h want 0", nm[i], act[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_single_frame();
        int errs;
        do_reset();
        run_frame(320, 240, 0, -1);
        total_cnt++;
        if (cap_addr.size() !== 81) $display("FAIL t1_count: got %0d want 81", cap_addr.size());
        else pass_cnt++;
        total_cnt++;
        if (cap_addr.size() > 0 && cap_addr[0] === 20'd458556) pass_cnt++;
        else $display("FAIL t1_first_addr: got %0d want 458556",
                      cap_addr.size() > 0 ? int'(cap_addr[0]) : -1);
        total_cnt++;
        if (cap_addr.size() == 81 && cap_addr[80] === 20'd463684) pass_cnt++;
        else $display("FAIL t1_last_addr: wrong or missing, want 463684");
        errs = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(exp_addr(1, 320, 240, i)) || cap_data[i] !== 8'hE0) errs++;
        total_cnt++;
        if (errs !== 0) $display("FAIL t1_sequence: got %0d bad writes want 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 83) $display("FAIL t1_swap_cycle: got %0d want 83", cap_swap_cycle);
        else pass_cnt++;
        total_cnt++;
        if (cap_gaps !== 1) $display("FAIL t1_gaps: got %0d want 1", cap_gaps);
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if ({front_buf, busy, buf_swap} !== 3'b100)
            $display("FAIL t1_after_swap: got front/busy/swap=%b want 100",
                     {front_buf, busy, buf_swap});
        else pass_cnt++;
    endtask

    task automatic test_double_buffer();
        int errs;
        do_reset();
        run_frame(320, 240, 0, -1);
        run_frame(330, 240, 0, -1);
        errs = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(exp_addr(0, 330, 240, i)) || cap_data[i] !== 8'hE0) errs++;
        total_cnt++;
        if (cap_addr.size() !== 81 || errs !== 0)
            $display("FAIL t2_frame2: got %0d writes, %0d bad; want 81, 0", cap_addr.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 83) $display("FAIL t2_frame2_swap: got %0d want 83", cap_swap_cycle);
        else pass_cnt++;
        run_frame(340, 240, 0, -1);
        errs = 0;
`ifdef PLAYER_BLIT_ERASE_EN
        for (int i = 0; i < cap_addr.size(); i++) begin
            if (i < 81) begin
                if (cap_addr[i] !== 20'(exp_addr(1, 320, 240, i)) || cap_data[i] !== 8'h00) errs++;
            end else begin
                if (cap_addr[i] !== 20'(exp_addr(1, 340, 240, i - 81)) || cap_data[i] !== 8'hE0)
                    errs++;
            end
        end
        total_cnt++;
        if (cap_addr.size() !== 162 || errs !== 0)
            $display("FAIL t2_frame3: got %0d writes, %0d bad; want 162, 0", cap_addr.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 164) $display("FAIL t2_frame3_swap: got %0d want 164", cap_swap_cycle);
        else pass_cnt++;
`else
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(exp_addr(1, 340, 240, i)) || cap_data[i] !== 8'hE0) errs++;
        total_cnt++;
        if (cap_addr.size() !== 81 || errs !== 0)
            $display("FAIL t2_frame3: got %0d writes, %0d bad; want 81, 0", cap_addr.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 83) $display("FAIL t2_frame3_swap: got %0d want 83", cap_swap_cycle);
        else pass_cnt++;
`endif
        @(negedge Clk);
        total_cnt++;
        if (front_buf !== 1'b1) $display("FAIL t2_front_buf: got %b want 1", front_buf);
        else pass_cnt++;
    endtask

    task automatic test_clip();
        int errs;
        do_reset();
        run_frame(2, 2, 0, -1);
        total_cnt++;
        if (cap_addr.size() !== 49) $display("FAIL t3_count: got %0d want 49", cap_addr.size());
        else pass_cnt++;
        total_cnt++;
        if (cap_addr.size() > 0 && cap_addr[0] === 20'd307200) pass_cnt++;
        else $display("FAIL t3_first_addr: wrong or missing, want 307200");
        errs = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(307200 + (i / 7) * 640 + i % 7) || cap_data[i] !== 8'hE0)
                errs++;
        total_cnt++;
        if (errs !== 0) $display("FAIL t3_sequence: got %0d bad writes want 0", errs);
        else pass_cnt++;
        // 1 latch cycle plus 32 clipped pixels
        total_cnt++;
        if (cap_gaps !== 33) $display("FAIL t3_gaps: got %0d want 33", cap_gaps);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 83) $display("FAIL t3_swap_cycle: got %0d want 83", cap_swap_cycle);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int errs;
        do_reset();
        run_frame(320, 240, 3, -1);
        errs = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(exp_addr(1, 320, 240, i)) || cap_data[i] !== 8'hE0) errs++;
        total_cnt++;
        if (cap_addr.size() !== 81 || errs !== 0)
            $display("FAIL t4_sequence: got %0d writes, %0d bad; want 81, 0", cap_addr.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_unstable !== 0) $display("FAIL t4_stable: got %0d changes want 0", cap_unstable);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 326) $display("FAIL t4_swap_cycle: got %0d want 326", cap_swap_cycle);
        else pass_cnt++;
        wr_ack = 1'b1;
    endtask

    task automatic test_overrun();
        int errs;
        do_reset();
        run_frame(320, 240, 0, 10);
        errs = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(exp_addr(1, 320, 240, i)) || cap_data[i] !== 8'hE0) errs++;
        total_cnt++;
        if (cap_addr.size() !== 81 || errs !== 0)
            $display("FAIL t5_blit: got %0d writes, %0d bad; want 81, 0", cap_addr.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 83) $display("FAIL t5_swap_cycle: got %0d want 83", cap_swap_cycle);
        else pass_cnt++;
        total_cnt++;
        if (frame_overrun !== 1'b1) $display("FAIL t5_overrun_set: got %b want 1", frame_overrun);
        else pass_cnt++;
        run_frame(100, 100, 0, -1);
        total_cnt++;
        if (frame_overrun !== 1'b1) $display("FAIL t5_overrun_sticky: got %b want 1", frame_overrun);
        else pass_cnt++;
        total_cnt++;
        if (cap_addr.size() !== 81) $display("FAIL t5_next_count: got %0d want 81", cap_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_blit();
        int errs;
        do_reset();
        run_frame(320, 240, 0, -1);
        run_frame(330, 240, 0, -1);
        @(negedge Clk);
        PlayerX = 10'd340;
        PlayerY = 10'd240;
        frame_start = 1'b1;
        wr_ack = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (9) @(negedge Clk);
`ifdef PLAYER_BLIT_ERASE_EN
        total_cnt++;
        if ({wr_req, wr_data} !== {1'b1, 8'h00})
            $display("FAIL t6_mid_erase: got req=%b data=%h want req=1 data=00", wr_req, wr_data);
        else pass_cnt++;
`else
        total_cnt++;
        if ({wr_req, wr_data} !== {1'b1, 8'hE0})
            $display("FAIL t6_mid_draw: got req=%b data=%h want req=1 data=e0", wr_req, wr_data);
        else pass_cnt++;
`endif
        Reset = 1'b1;
        @(negedge Clk);
        total_cnt++;
        if ({wr_req, front_buf, busy} !== 3'b000)
            $display("FAIL t6_after_reset: got req/front/busy=%b want 000",
                     {wr_req, front_buf, busy});
        else pass_cnt++;
        Reset = 1'b0;
        run_frame(340, 240, 0, -1);
        errs = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] !== 20'(exp_addr(1, 340, 240, i)) || cap_data[i] !== 8'hE0) errs++;
        total_cnt++;
        if (cap_addr.size() !== 81 || errs !== 0)
            $display("FAIL t6_fresh_draw: got %0d writes, %0d bad; want 81, 0", cap_addr.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cap_swap_cycle !== 83) $display("FAIL t6_swap_cycle: got %0d want 83", cap_swap_cycle);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_double_buffer();
        test_clip();
        test_backpressure();
        test_overrun();
        test_reset_mid_blit();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
